// File: rtl/dot_line_feeder.sv
// dot_line_feeder: packs a valid/ready stream of weight/feature element pairs
// into two line registers for a combinational dot-product unit. After one
// settle cycle it captures the returned mul_out and offers it downstream on a
// valid/ready result port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     element-pair stream handshake
//   in_weight/in_feature  element pair (unsigned, WEIGHT_WIDTH bits)
//   in_last               closes the current line early
//   weight_line           packed weight line to the dot-product unit
//   feature_line          packed feature line to the dot-product unit
//   mul_out               dot product returned by the dot-product unit
//   res_valid/res_ready   result handshake
//   res_data              captured dot product
//   res_count             number of elements in the captured line
module dot_line_feeder #(
  parameter int unsigned WEIGHT_ROWS    = 96,
  parameter int unsigned WEIGHT_WIDTH   = 5,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  localparam int unsigned CNT_W         = $clog2(WEIGHT_ROWS + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WEIGHT_WIDTH-1:0]                  in_weight,
  input  logic [WEIGHT_WIDTH-1:0]                  in_feature,
  input  logic                                     in_last,
  output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] weight_line,
  output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] feature_line,
  input  logic [DOT_PROD_WIDTH-1:0]                mul_out,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [DOT_PROD_WIDTH-1:0]                res_data,
  output logic [CNT_W-1:0]                         res_count
);

  localparam int unsigned IDX_W = $clog2(WEIGHT_ROWS);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e                                   state_q, state_d;
  logic [CNT_W-1:0]                         idx_q, idx_d;
  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] wline_q, wline_d;
  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] fline_q, fline_d;
  logic [DOT_PROD_WIDTH-1:0]                res_data_q, res_data_d;
  logic [CNT_W-1:0]                         res_count_q, res_count_d;

  logic accept;
  logic line_close;
  logic res_fire;

  // Handshake qualifiers use registered state only.
  assign accept     = in_valid && (state_q == FILL);
  assign res_fire   = res_ready && (state_q == HOLD);
  // A line closes on in_last or when the final slot is written.
  assign line_close = in_last || (idx_q == CNT_W'(WEIGHT_ROWS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && line_close) state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (res_fire) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      FILL:    in_ready  = 1'b1;
      HOLD:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // Line fill, result capture and line clear after the result handshake.
  always_comb begin
    idx_d       = idx_q;
    wline_d     = wline_q;
    fline_d     = fline_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    if (accept) begin
      wline_d[idx_q[IDX_W-1:0]] = in_weight;
      fline_d[idx_q[IDX_W-1:0]] = in_feature;
      idx_d                     = idx_q + CNT_W'(1);
      if (line_close) res_count_d = idx_q + CNT_W'(1);
    end
    // mul_out has had a full cycle to settle on the stable lines.
    if (state_q == CAPTURE) res_data_d = mul_out;
    // Clearing the lines makes unwritten entries of a short line contribute 0.
    if (res_fire) begin
      idx_d   = '0;
      wline_d = '0;
      fline_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      wline_q     <= '0;
      fline_q     <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      idx_q       <= idx_d;
      wline_q     <= wline_d;
      fline_q     <= fline_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

  assign weight_line  = wline_q;
  assign feature_line = fline_q;
  assign res_data     = res_data_q;
  assign res_count    = res_count_q;

endmodule

// File: tb/tb_dot_line_feeder.sv
// Bench for dot_line_feeder: a behavioural dot-product unit drives mul_out, a
// transaction-level model tracks accepted pairs and expected results, and a
// compare process checks every output on every falling edge.
module tb_dot_line_feeder;

  localparam int unsigned ROWS = 96;
  localparam int unsigned WW   = 5;
  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 7;

  logic                          clk;
  logic                          rst_n;
  logic                          in_valid;
  logic                          in_ready;
  logic [WW-1:0]                 in_weight;
  logic [WW-1:0]                 in_feature;
  logic                          in_last;
  logic [0:ROWS-1][WW-1:0]       weight_line;
  logic [0:ROWS-1][WW-1:0]       feature_line;
  logic [DW-1:0]                 mul_out;
  logic                          res_valid;
  logic                          res_ready;
  logic [DW-1:0]                 res_data;
  logic [CW-1:0]                 res_count;

  int n_total = 0;
  int n_pass  = 0;

  dot_line_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_weight    (in_weight),
    .in_feature   (in_feature),
    .in_last      (in_last),
    .weight_line  (weight_line),
    .feature_line (feature_line),
    .mul_out      (mul_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_count    (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational dot-product unit.
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < ROWS; i++) s += int'(weight_line[i]) * int'(feature_line[i]);
    mul_out = DW'(s);
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Transaction-level model: accepted pairs per line, result when it is due.
  typedef enum int {M_FILL, M_CAP, M_HOLD} mphase_e;
  mphase_e             ph = M_FILL;
  logic [0:ROWS-1][WW-1:0] mw = '0;
  logic [0:ROWS-1][WW-1:0] mf = '0;
  int                  n = 0;
  logic [DW-1:0]       e_res = '0;
  logic [CW-1:0]       e_cnt = '0;

  function automatic logic [DW-1:0] dot_of(input logic [0:ROWS-1][WW-1:0] a,
                                            input logic [0:ROWS-1][WW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < ROWS; i++) s += int'(a[i]) * int'(b[i]);
    return DW'(s % 65536);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = M_FILL; mw = '0; mf = '0; n = 0; e_res = '0; e_cnt = '0;
    end else begin
      case (ph)
        M_FILL: if (in_valid) begin
          mw[n] = in_weight;
          mf[n] = in_feature;
          n++;
          if (in_last || n == int'(ROWS)) begin
            e_cnt = CW'(n);
            ph = M_CAP;
          end
        end
        M_CAP: begin
          e_res = dot_of(mw, mf);
          ph = M_HOLD;
        end
        default: if (res_ready) begin
          mw = '0; mf = '0; n = 0; ph = M_FILL;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    #4;
    forever begin
      @(negedge clk);
      #1;
      check("in_ready", 512'(in_ready), 512'(ph == M_FILL));
      check("res_valid", 512'(res_valid), 512'(ph == M_HOLD));
      check("res_data", 512'(res_data), 512'(e_res));
      check("res_count", 512'(res_count), 512'(e_cnt));
      check("weight_line", 512'(weight_line), 512'(mw));
      check("feature_line", 512'(feature_line), 512'(mf));
    end
  end

  // Drive one pair, waiting (bounded) for acceptance; called and returns at negedge.
  task automatic beat(input logic [WW-1:0] w, input logic [WW-1:0] f, input logic last,
                      input int gap);
    int g;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid   = 1'b1;
    in_weight  = w;
    in_feature = f;
    in_last    = last;
    g = 0;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("accept_timeout", 512'(0), 512'(1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, optionally stall, then take it.
  task automatic collect(input int stall);
    int g;
    in_valid = 1'b0;
    g = 0;
    while (!res_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("result_timeout", 512'(0), 512'(1));
    repeat (stall) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_weight = '0; in_feature = '0;
    in_last = 1'b0; res_ready = 1'b0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", 512'(in_ready), 512'(1));
    check("rst_res_valid", 512'(res_valid), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 96 x (1,1) with in_last on the 96th; result visible 2 edges after last accept.
    for (int i = 0; i < 96; i++) beat(5'd1, 5'd1, logic'(i == 95), 0);
    #1;
    check("lat_capture_valid", 512'(res_valid), 512'(0));
    @(negedge clk);
    #1;
    check("lat_hold_valid", 512'(res_valid), 512'(1));
    check("ones_data", 512'(res_data), 512'(96));
    check("ones_count", 512'(res_count), 512'(96));
    collect(0);

    // Short line; then 10-cycle stall in HOLD with in_valid high.
    beat(5'd2, 5'd3, 1'b0, 0);
    beat(5'd4, 5'd5, 1'b0, 0);
    beat(5'd31, 5'd31, 1'b1, 0);
    @(negedge clk);
    check("short_data", 512'(res_data), 512'(987));
    check("short_count", 512'(res_count), 512'(3));
    check("short_tail_zero", 512'(weight_line[3:95]), 512'(0));
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_weight = WW'($urandom); in_feature = WW'($urandom); in_last = 1'($urandom);
      @(negedge clk);
    end
    #1;
    check("stall_data", 512'(res_data), 512'(987));
    check("stall_in_ready", 512'(in_ready), 512'(0));
    check("stall_valid", 512'(res_valid), 512'(1));
    in_valid = 1'b0; in_last = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("hs_in_ready", 512'(in_ready), 512'(1));
    check("hs_lines_zero", 512'(weight_line), 512'(0));

    // 96 x (31,31) with and without in_last: wraps to 26720.
    for (int i = 0; i < 96; i++) beat(5'd31, 5'd31, logic'(i == 95), 0);
    @(negedge clk);
    check("max_data", 512'(res_data), 512'(26720));
    check("max_count", 512'(res_count), 512'(96));
    collect(2);
    for (int i = 0; i < 96; i++) beat(5'd31, 5'd31, 1'b0, 0);
    @(negedge clk);
    check("nolast_data", 512'(res_data), 512'(26720));
    check("nolast_count", 512'(res_count), 512'(96));
    collect(1);

    // Reset after 40 accepted elements, then a 2-element line.
    for (int i = 0; i < 40; i++) beat(WW'($urandom), WW'($urandom), 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 512'(in_ready), 512'(1));
    check("mid_rst_data", 512'(res_data), 512'(0));
    check("mid_rst_count", 512'(res_count), 512'(0));
    check("mid_rst_line", 512'(feature_line), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(5'd1, 5'd1, 1'b0, 0);
    beat(5'd1, 5'd1, 1'b1, 0);
    @(negedge clk);
    check("two_data", 512'(res_data), 512'(2));
    check("two_count", 512'(res_count), 512'(2));
    collect(0);

    // Ramp w=f=i mod 32 with ~50% valid gaps.
    for (int i = 0; i < 96; i++)
      beat(WW'(i % 32), WW'(i % 32), logic'(i == 95), int'($urandom_range(0, 1)));
    @(negedge clk);
    check("ramp_data", 512'(res_data), 512'(31248));
    check("ramp_count", 512'(res_count), 512'(96));
    collect(0);

    // Random lines of random length; res_ready pre-asserted on some.
    for (int l = 0; l < 6; l++) begin
      int len;
      len = int'($urandom_range(1, 96));
      for (int i = 0; i < len; i++)
        beat(WW'($urandom), WW'($urandom), logic'(i == len - 1), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) res_ready = 1'b1;
      collect(int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
